jtframe_romarb2: RTL and testbench

JTFRAME_ROMARB2 -- requirements
Module: jtframe_romarb2

---
 rtl/jtframe_romarb2.sv | 138 +++++++++++++
 tb/tb_jtframe_romarb2.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_romarb2.sv
// Two-requester ROM arbiter: each requester keeps a one-entry data latch and
// misses are served one at a time on a shared ROM port, round-robin on ties.
module jtframe_romarb2 #(
   parameter int AW = 12,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          a_cs,
   input  logic [AW-1:0] a_addr,
   output logic [DW-1:0] a_data,
   output logic          a_ok,
   input  logic          b_cs,
   input  logic [AW-1:0] b_addr,
   output logic [DW-1:0] b_data,
   output logic          b_ok,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   input  logic          rom_ok,
   output logic          busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FETCH} state_e;
   typedef enum logic {REQ_A, REQ_B} req_e;

   state_e        state_q, state_d;
   req_e          gnt_q, gnt_d;
   req_e          last_q, last_d;
   logic          discard_q, discard_d;
   logic          rom_cs_q, rom_cs_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [AW-1:0] a_laddr_q, a_laddr_d, b_laddr_q, b_laddr_d;
   logic [DW-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
   logic          a_valid_q, a_valid_d, b_valid_q, b_valid_d;
   logic          a_pend, b_pend;
   req_e          pick;

   assign a_ok     = a_cs & a_valid_q & (a_addr == a_laddr_q);
   assign b_ok     = b_cs & b_valid_q & (b_addr == b_laddr_q);
   assign a_data   = a_data_q;
   assign b_data   = b_data_q;
   assign rom_cs   = rom_cs_q;
   assign rom_addr = rom_addr_q;
   assign busy     = (state_q != ST_IDLE);

   assign a_pend = a_cs & ~a_ok;
   assign b_pend = b_cs & ~b_ok;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      rom_cs_d   = rom_cs_q;
      rom_addr_d = rom_addr_q;
      a_laddr_d  = a_laddr_q;
      b_laddr_d  = b_laddr_q;
      a_data_d   = a_data_q;
      b_data_d   = b_data_q;
      a_valid_d  = a_valid_q & ~flush;
      b_valid_d  = b_valid_q & ~flush;
      discard_d  = discard_q | (flush & (state_q != ST_IDLE));
      pick       = (a_pend & b_pend) ? ((last_q == REQ_A) ? REQ_B : REQ_A)
                                     : (a_pend ? REQ_A : REQ_B);

      case (state_q)
         ST_IDLE: begin
            if (a_pend | b_pend) begin
               gnt_d     = pick;
               rom_cs_d  = 1'b1;
               discard_d = 1'b0;
               state_d   = ST_WAIT;
               if (pick == REQ_A) begin
                  rom_addr_d = a_addr;
                  a_laddr_d  = a_addr;
                  a_valid_d  = 1'b0;
               end else begin
                  rom_addr_d = b_addr;
                  b_laddr_d  = b_addr;
                  b_valid_d  = 1'b0;
               end
            end
         end
         // rom_ok may still belong to the previous access here, so it is ignored.
         ST_WAIT: state_d = ST_FETCH;
         ST_FETCH: begin
            if (rom_ok) begin
               rom_cs_d = 1'b0;
               last_d   = gnt_q;
               state_d  = ST_IDLE;
               if (gnt_q == REQ_A) begin
                  a_data_d  = rom_data;
                  a_valid_d = ~(discard_q | flush);
               end else begin
                  b_data_d  = rom_data;
                  b_valid_d = ~(discard_q | flush);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the data latches are reset too, so a_data/b_data are defined from time zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= REQ_A;
         last_q     <= REQ_B;
         discard_q  <= 1'b0;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
         a_laddr_q  <= '0;
         b_laddr_q  <= '0;
         a_data_q   <= '0;
         b_data_q   <= '0;
         a_valid_q  <= 1'b0;
         b_valid_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values.
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         discard_q  <= discard_d;
         rom_cs_q   <= rom_cs_d;
         rom_addr_q <= rom_addr_d;
         a_laddr_q  <= a_laddr_d;
         b_laddr_q  <= b_laddr_d;
         a_data_q   <= a_data_d;
         b_data_q   <= b_data_d;
         a_valid_q  <= a_valid_d;
         b_valid_q  <= b_valid_d;
      end
   end

endmodule

// File: tb/tb_jtframe_romarb2.sv
// Directed bench for jtframe_romarb2: a ROM model that drives junk data during
// the blanking cycle, a grant-address scoreboard and explicit data checks.
module tb_jtframe_romarb2;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n, flush;
   logic          a_cs, b_cs;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_ok, b_ok;
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          rom_ok, rom_ok_r;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] cur_addr = '0;
   logic          prev_cs  = 1'b0;
   int unsigned   cs_cycles;

   jtframe_romarb2 #(.AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .a_cs     (a_cs),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .a_ok     (a_ok),
      .b_cs     (b_cs),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .b_ok     (b_ok),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      return a[7:0] + 8'h36 + {4'h0, a[11:8]};
   endfunction

   // Junk data while rom_cs has been high for less than one full cycle (the WAIT slot).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cs_cycles <= 0;
      else        cs_cycles <= rom_cs ? cs_cycles + 1 : 0;
   end
   always_comb begin
      rom_ok   = rom_ok_r;
      rom_data = (cs_cycles == 0) ? 8'hEE : rom_fn(rom_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Grant scoreboard: each new rom_cs must carry the next expected address and hold it.
   always @(negedge clk) begin
      if (rom_cs && !prev_cs) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL grant_unexpected observed=0x%0h expected=none", rom_addr);
         end
         if (exp_q.size() != 0) begin
            cur_addr = exp_q.pop_front();
            check("grant_addr", rom_addr, cur_addr);
         end
      end else if (rom_cs) begin
         check("rom_addr_stable", rom_addr, cur_addr);
      end
      prev_cs = rom_cs;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; a_cs = 1'b0; b_cs = 1'b0;
      a_addr = '0; b_addr = '0; rom_ok_r = 1'b1;
      #3;
      check("rst_rom_cs", rom_cs, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_a_ok", a_ok, 0);
      check("rst_b_ok", b_ok, 0);
      check("rst_a_data", a_data, 0);
      check("rst_b_data", b_data, 0);
      cyc(2);
      rst_n = 1'b1;

      // Single requester miss, then hit
      a_addr = 12'h123; a_cs = 1'b1; exp_q.push_back(12'h123);
      #1 check("a_miss_initial", a_ok, 0);
      cyc(1);
      check("grant_rom_cs", rom_cs, 1);
      check("grant_busy", busy, 1);
      check("wait_a_ok", a_ok, 0);
      cyc(1);
      check("fetch_a_ok", a_ok, 0);
      cyc(1);
      check("done_a_ok", a_ok, 1);
      check("done_a_data", a_data, 8'h5A);
      check("done_rom_cs", rom_cs, 0);
      cyc(2);
      check("hit_a_ok", a_ok, 1);
      check("hit_busy", busy, 0);
      a_addr = 12'h023; exp_q.push_back(12'h023);
      #1 check("full_width_cmp", a_ok, 0);
      cyc(3);
      check("a023_ok", a_ok, 1);
      check("a023_data", a_data, rom_fn(12'h023));
      a_cs = 1'b0;

      // Tie straight out of reset: A first, then B after a mandatory idle cycle
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      a_addr = 12'h010; b_addr = 12'h020; a_cs = 1'b1; b_cs = 1'b1;
      exp_q.push_back(12'h010); exp_q.push_back(12'h020);
      cyc(3);
      check("tie_a_ok", a_ok, 1);
      check("tie_a_data", a_data, 8'h46);
      check("tie_b_pending", b_ok, 0);
      check("tie_idle_gap", rom_cs, 0);
      cyc(3);
      check("tie_b_ok", b_ok, 1);
      check("tie_b_data", b_data, 8'h56);
      check("tie_a_keep", a_ok, 1);

      // Round robin after A served last; A address changes mid-fetch
      b_cs = 1'b0; a_addr = 12'h030; exp_q.push_back(12'h030);
      cyc(1);
      a_addr = 12'h032; b_addr = 12'h031; b_cs = 1'b1;
      exp_q.push_back(12'h031); exp_q.push_back(12'h032);
      cyc(2);
      check("rr_a_stale_ok", a_ok, 0);
      check("rr_a_latched_data", a_data, rom_fn(12'h030));
      cyc(3);
      check("rr_b_first_ok", b_ok, 1);
      check("rr_b_data", b_data, rom_fn(12'h031));
      check("rr_a_waiting", a_ok, 0);
      cyc(3);
      check("rr_a_ok", a_ok, 1);
      check("rr_a_data", a_data, rom_fn(12'h032));

      // Flush during WAIT, then rom_ok withheld for several cycles
      b_cs = 1'b0; rom_ok_r = 1'b0; a_addr = 12'h040; exp_q.push_back(12'h040);
      cyc(1);
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
      check("stall_busy0", busy, 1);
      cyc(3);
      check("stall_busy", busy, 1);
      check("stall_rom_cs", rom_cs, 1);
      check("stall_a_ok", a_ok, 0);
      rom_ok_r = 1'b1; exp_q.push_back(12'h040);
      cyc(1);
      check("discard_a_ok", a_ok, 0);
      check("discard_busy", busy, 0);
      check("discard_a_data", a_data, rom_fn(12'h040));
      cyc(3);
      check("refetch_a_ok", a_ok, 1);
      check("refetch_a_data", a_data, rom_fn(12'h040));

      // Flush on the completion edge
      a_addr = 12'h041; exp_q.push_back(12'h041);
      cyc(2);
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
      check("flush_done_a_ok", a_ok, 0);
      check("flush_done_busy", busy, 0);
      exp_q.push_back(12'h041);
      cyc(3);
      check("after_flush_a_ok", a_ok, 1);
      check("after_flush_a_data", a_data, rom_fn(12'h041));

      // Flush while idle drops an existing hit
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
      check("flush_idle_a_ok", a_ok, 0);
      exp_q.push_back(12'h041);
      cyc(3);
      check("flush_idle_refill", a_ok, 1);

      // Address change during FETCH: old address completes, new one misses
      rom_ok_r = 1'b0; a_addr = 12'h100; exp_q.push_back(12'h100);
      cyc(2);
      a_addr = 12'h101; exp_q.push_back(12'h101); rom_ok_r = 1'b1;
      cyc(1);
      check("chg_a_ok", a_ok, 0);
      check("chg_a_data", a_data, rom_fn(12'h100));
      check("chg_busy", busy, 0);
      cyc(3);
      check("chg_new_ok", a_ok, 1);
      check("chg_new_data", a_data, rom_fn(12'h101));

      // Asynchronous reset in the middle of a stalled fetch
      rom_ok_r = 1'b0; a_addr = 12'h2A0; exp_q.push_back(12'h2A0);
      cyc(2);
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("arst_rom_cs", rom_cs, 0);
      check("arst_busy", busy, 0);
      check("arst_a_ok", a_ok, 0);
      check("arst_b_ok", b_ok, 0);
      check("arst_rom_addr", rom_addr, 0);
      cyc(1);
      rom_ok_r = 1'b1; rst_n = 1'b1; exp_q.push_back(12'h2A0);
      cyc(3);
      check("post_rst_a_ok", a_ok, 1);
      check("post_rst_a_data", a_data, 8'hD8);
      a_cs = 1'b0;
      cyc(2);

      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL sb_empty observed=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
